// File: rtl/pipe_pkg.sv
// Shared types and constants for pipeline-boundary registers (MEM/WB instance).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_pkg;

  // MEM/WB control field: which writeback source, and whether to write at all.
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } memwb_ctrl_t;

  // Payload layout, LSB first: wbAddr[4:0], aluResult[36:5], memData[68:37].
  localparam int WB_ADDR_W     = 5;
  localparam int ALU_RES_W     = 32;
  localparam int MEM_DATA_W    = 32;
  localparam int WB_ADDR_LSB   = 0;
  localparam int ALU_RES_LSB   = WB_ADDR_LSB + WB_ADDR_W;
  localparam int MEM_DATA_LSB  = ALU_RES_LSB + ALU_RES_W;

  localparam int MEMWB_CTRL_W  = $bits(memwb_ctrl_t);
  localparam int MEMWB_DATA_W  = MEM_DATA_LSB + MEM_DATA_W;

  // Assemble a MEM/WB payload from its three fields.
  function automatic logic [MEMWB_DATA_W-1:0] pack_memwb(
    input logic [MEM_DATA_W-1:0] mem_data,
    input logic [ALU_RES_W-1:0]  alu_result,
    input logic [WB_ADDR_W-1:0]  wb_addr
  );
    return {mem_data, alu_result, wb_addr};
  endfunction

  // Field extractors for the consumer side.
  function automatic logic [WB_ADDR_W-1:0] memwb_wb_addr(input logic [MEMWB_DATA_W-1:0] p);
    return p[WB_ADDR_LSB +: WB_ADDR_W];
  endfunction

  function automatic logic [ALU_RES_W-1:0] memwb_alu_result(input logic [MEMWB_DATA_W-1:0] p);
    return p[ALU_RES_LSB +: ALU_RES_W];
  endfunction

  function automatic logic [MEM_DATA_W-1:0] memwb_mem_data(input logic [MEMWB_DATA_W-1:0] p);
    return p[MEM_DATA_LSB +: MEM_DATA_W];
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: valid bit, control field (zeroed when invalid), payload.
// Latency: 1 cycle from load to output.
// Backpressure: holds everything while load=0; flush clears valid/ctrl but keeps data.
module pipe_stage_cell
  import pipe_pkg::*;
#(
  parameter int CTRL_W = MEMWB_CTRL_W,
  parameter int DATA_W = MEMWB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              data_en,
  input  logic              valid_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid_q,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [DATA_W-1:0] data_q
);

  // Priority rst > flush > load; ctrl is forced to zero whenever the entry is a bubble,
  // while data only moves when data_en allows it (stage 0 keeps old data on a bubble).
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load) begin
      valid_q <= valid_d;
      ctrl_q  <= valid_d ? ctrl_d : '0;
      if (data_en) begin
        data_q <= data_d;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Multi-stage pipeline-boundary register with flush, bubbles, occupancy and stall counting.
// Latency: exactly DEPTH clock edges from input to valid_o/ctrl_o/data_o.
// Backpressure: stall_i freezes every stage and ignores the input; flush_i overrides stall.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = MEMWB_CTRL_W,
  parameter int DATA_W = MEMWB_DATA_W,
  parameter int DEPTH  = 1,   // must be at least 1
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [CTRL_W-1:0]          ctrl_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       valid_o,
  output logic [CTRL_W-1:0]          ctrl_o,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(DEPTH+1)-1:0] occ_o,
  output logic [CNT_W-1:0]           stall_cnt_o
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  // Stages advance together only when neither flush nor stall is active.
  logic advance;
  assign advance = !stall_i && !flush_i;

  logic [DEPTH-1:0] stg_valid;
  logic [CTRL_W-1:0] stg_ctrl [DEPTH];
  logic [DATA_W-1:0] stg_data [DEPTH];

  logic [DEPTH-1:0] in_valid;
  logic [DEPTH-1:0] in_data_en;
  logic [CTRL_W-1:0] in_ctrl [DEPTH];
  logic [DATA_W-1:0] in_data [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      // Head stage: payload is captured only for real entries, so a bubble leaves it intact.
      assign in_valid[g]   = valid_i;
      assign in_ctrl[g]    = ctrl_i;
      assign in_data[g]    = data_i;
      assign in_data_en[g] = valid_i;
    end else begin : g_body
      // Later stages shift their neighbour unconditionally, bubbles included.
      assign in_valid[g]   = stg_valid[g-1];
      assign in_ctrl[g]    = stg_ctrl[g-1];
      assign in_data[g]    = stg_data[g-1];
      assign in_data_en[g] = 1'b1;
    end

    pipe_stage_cell #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_cell (
      .clk     (clk_i),
      .rst     (rst_i),
      .flush   (flush_i),
      .load    (advance),
      .data_en (in_data_en[g]),
      .valid_d (in_valid[g]),
      .ctrl_d  (in_ctrl[g]),
      .data_d  (in_data[g]),
      .valid_q (stg_valid[g]),
      .ctrl_q  (stg_ctrl[g]),
      .data_q  (stg_data[g])
    );
  end

  assign valid_o = stg_valid[DEPTH-1];
  assign ctrl_o  = stg_ctrl[DEPTH-1];
  assign data_o  = stg_data[DEPTH-1];

  // Occupancy tracked incrementally alongside the valids so the output is a plain flop;
  // modular arithmetic keeps the transient occ+1 harmless when the pipe is full.
  logic [OCC_W-1:0] occ_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      occ_q <= '0;
    end else if (!stall_i) begin
      occ_q <= occ_q + OCC_W'(valid_i) - OCC_W'(stg_valid[DEPTH-1]);
    end
  end
  assign occ_o = occ_q;

  // Saturating stall-cycle counter; a stall is counted even when flush wins that cycle.
  logic [CNT_W-1:0] stall_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (DEPTH 3, DEPTH 2 with 4-bit counter, DEPTH 1).
// Expected outputs come from constants and a per-instance scoreboard queue.
// Every check is an immediate assertion; failures are counted and the run always reaches its summary.
module tb_pipe_stage_reg;

  localparam int CW = 2;
  localparam int DW = 69;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  exp_t q3[$];
  exp_t q2[$];

  // DEPTH = 3 instance
  logic rst3, stall3, flush3, vin3, vout3;
  logic [CW-1:0] cin3, cout3;
  logic [DW-1:0] din3, dout3;
  logic [1:0] occ3;
  logic [15:0] cnt3;

  // DEPTH = 2, CNT_W = 4 instance
  logic rst2, stall2, flush2, vin2, vout2;
  logic [CW-1:0] cin2, cout2;
  logic [DW-1:0] din2, dout2;
  logic [1:0] occ2;
  logic [3:0] cnt2;

  // DEPTH = 1 instance
  logic rst1, stall1, flush1, vin1, vout1;
  logic [CW-1:0] cin1, cout1;
  logic [DW-1:0] din1, dout1;
  logic [0:0] occ1;
  logic [15:0] cnt1;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3), .CNT_W(16)) u_d3 (
    .clk_i(clk), .rst_i(rst3), .stall_i(stall3), .flush_i(flush3), .valid_i(vin3),
    .ctrl_i(cin3), .data_i(din3), .valid_o(vout3), .ctrl_o(cout3), .data_o(dout3),
    .occ_o(occ3), .stall_cnt_o(cnt3));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2), .CNT_W(4)) u_d2 (
    .clk_i(clk), .rst_i(rst2), .stall_i(stall2), .flush_i(flush2), .valid_i(vin2),
    .ctrl_i(cin2), .data_i(din2), .valid_o(vout2), .ctrl_o(cout2), .data_o(dout2),
    .occ_o(occ2), .stall_cnt_o(cnt2));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(1), .CNT_W(16)) u_d1 (
    .clk_i(clk), .rst_i(rst1), .stall_i(stall1), .flush_i(flush1), .valid_i(vin1),
    .ctrl_i(cin1), .data_i(din1), .valid_o(vout1), .ctrl_o(cout1), .data_o(dout1),
    .occ_o(occ1), .stall_cnt_o(cnt1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop3(input string tag);
    exp_t e;
    if (q3.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed output with empty scoreboard, expected queued entry", tag);
    end else begin
      e = q3.pop_front();
      chk({tag, "_valid"}, vout3, 1);
      chk({tag, "_ctrl"}, cout3, e.c);
      chk({tag, "_data"}, dout3, e.d);
    end
  endtask

  task automatic pop2(input string tag);
    exp_t e;
    if (q2.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed output with empty scoreboard, expected queued entry", tag);
    end else begin
      e = q2.pop_front();
      chk({tag, "_valid"}, vout2, 1);
      chk({tag, "_ctrl"}, cout2, e.c);
      chk({tag, "_data"}, dout2, e.d);
    end
  endtask

  task automatic push3(input logic [CW-1:0] c, input logic [DW-1:0] d);
    vin3 = 1'b1; cin3 = c; din3 = d;
    q3.push_back('{c: c, d: d});
  endtask

  task automatic push2(input logic [CW-1:0] c, input logic [DW-1:0] d);
    vin2 = 1'b1; cin2 = c; din2 = d;
    q2.push_back('{c: c, d: d});
  endtask

  initial begin
    rst3 = 1'b1; stall3 = 1'b0; flush3 = 1'b0; vin3 = 1'b0; cin3 = '0; din3 = '0;
    rst2 = 1'b1; stall2 = 1'b0; flush2 = 1'b0; vin2 = 1'b0; cin2 = '0; din2 = '0;
    rst1 = 1'b1; stall1 = 1'b0; flush1 = 1'b0; vin1 = 1'b0; cin1 = '0; din1 = '0;

    // Power-up reset: everything must be a known zero after the first edge.
    tick();
    chk("rst3_valid", vout3, 0);
    chk("rst3_ctrl",  cout3, 0);
    chk("rst3_data",  dout3, 0);
    chk("rst3_occ",   occ3,  0);
    chk("rst3_cnt",   cnt3,  0);
    chk("rst2_data",  dout2, 0);
    chk("rst1_occ",   occ1,  0);
    rst3 = 1'b0; rst2 = 1'b0; rst1 = 1'b0;

    // Latency and order on DEPTH=3.
    push3(2'b11, 69'hA5);
    tick();
    chk("lat_e1_valid", vout3, 0);
    chk("lat_e1_occ",   occ3,  1);
    push3(2'b11, 69'h5A);
    tick();
    chk("lat_e2_valid", vout3, 0);
    chk("lat_e2_occ",   occ3,  2);
    vin3 = 1'b0; cin3 = '0; din3 = '0;
    tick();
    pop3("lat_e3");
    chk("lat_e3_occ", occ3, 2);
    tick();
    pop3("lat_e4");
    chk("lat_e4_occ", occ3, 1);
    tick();
    chk("lat_e5_valid", vout3, 0);
    chk("lat_e5_ctrl",  cout3, 0);
    chk("lat_e5_occ",   occ3,  0);

    // Reset mid-stream (overrides a concurrent stall) on DEPTH=3.
    push3(2'b01, 69'h1); tick();
    push3(2'b01, 69'h2); tick();
    push3(2'b01, 69'h3); tick();
    pop3("mid_first");
    vin3 = 1'b0; stall3 = 1'b1;
    tick();
    chk("mid_stall_data", dout3, 69'h1);
    chk("mid_stall_cnt",  cnt3,  1);
    rst3 = 1'b1;
    tick();
    chk("mid_rst_valid", vout3, 0);
    chk("mid_rst_ctrl",  cout3, 0);
    chk("mid_rst_data",  dout3, 0);
    chk("mid_rst_occ",   occ3,  0);
    chk("mid_rst_cnt",   cnt3,  0);
    q3.delete();
    rst3 = 1'b0; stall3 = 1'b0;

    // Flush over stall on DEPTH=3 with occ=2 and a valid entry at the output.
    push3(2'b10, 69'h11); tick();
    push3(2'b10, 69'h22); tick();
    vin3 = 1'b0; cin3 = '0;
    tick();
    pop3("fl_pre");
    chk("fl_pre_occ", occ3, 2);
    flush3 = 1'b1; stall3 = 1'b1;
    tick();
    chk("fl_valid", vout3, 0);
    chk("fl_ctrl",  cout3, 0);
    chk("fl_occ",   occ3,  0);
    chk("fl_data",  dout3, 69'h11);
    chk("fl_cnt",   cnt3,  1);
    q3.delete();
    flush3 = 1'b0; stall3 = 1'b0;
    tick();
    chk("fl_post_valid", vout3, 0);
    chk("fl_post_ctrl",  cout3, 0);
    chk("fl_post_data",  dout3, 69'h22);

    // Stall hold on a full DEPTH=2 pipe; input keeps changing and must be ignored.
    push2(2'b01, 69'h31); tick();
    push2(2'b10, 69'h32); tick();
    pop2("st_full");
    chk("st_full_occ", occ2, 2);
    stall2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vin2 = 1'b1; cin2 = 2'b11; din2 = 69'h1F0 + DW'(i);
      tick();
      chk("st_hold_valid", vout2, 1);
      chk("st_hold_ctrl",  cout2, 2'b01);
      chk("st_hold_data",  dout2, 69'h31);
      chk("st_hold_occ",   occ2,  2);
    end
    chk("st_cnt4", cnt2, 4);
    stall2 = 1'b0; vin2 = 1'b0; cin2 = '0;
    tick();
    pop2("st_resume");
    chk("st_resume_occ", occ2, 1);
    tick();
    chk("st_drain_valid", vout2, 0);
    chk("st_drain_ctrl",  cout2, 0);
    chk("st_drain_occ",   occ2,  0);

    // Counter saturation at 15 for CNT_W=4.
    stall2 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_cnt9", cnt2, 9);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_cnt15", cnt2, 15);
    for (int i = 0; i < 9; i++) tick();
    chk("sat_hold15", cnt2, 15);
    stall2 = 1'b0;

    // Bubble on DEPTH=1: ctrl cleared, payload holds.
    vin1 = 1'b1; cin1 = 2'b01; din1 = 69'h10;
    tick();
    chk("bub_v_valid", vout1, 1);
    chk("bub_v_ctrl",  cout1, 2'b01);
    chk("bub_v_data",  dout1, 69'h10);
    chk("bub_v_occ",   occ1,  1);
    vin1 = 1'b0; cin1 = 2'b11; din1 = 69'hFF;
    tick();
    chk("bub_valid", vout1, 0);
    chk("bub_ctrl",  cout1, 0);
    chk("bub_data",  dout1, 69'h10);
    chk("bub_occ",   occ1,  0);
    vin1 = 1'b1; cin1 = 2'b10; din1 = 69'h44;
    tick();
    chk("bub_next_data", dout1, 69'h44);
    chk("bub_next_occ",  occ1,  1);
    chk("bub_cnt",       cnt1,  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
